// File: rtl/btn_conditioner.sv
// Push-button front end: per-button 2-flop sync, debounce, press strobe and
// optional auto-repeat. Every output is registered; there is no raw-to-output path.

module btn_conditioner_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic          s1_q, s2_q;
    logic          stable_d, stable_q, prev_q;
    logic [DW-1:0] db_cnt_d, db_cnt_q;
    logic [RW-1:0] rcnt_q;
    logic          pulse_q;
    logic          press;
    state_t        state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (s2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) stable_d = s2_q;
            else                     db_cnt_d = db_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            prev_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            prev_q   <= stable_q;
        end
    end

    assign press = stable_q & ~prev_q;

    // Press can only occur in IDLE, so press and repeat strobes never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= press;
            if (!REPEAT_EN || !stable_q) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        rcnt_q <= '0;
                        if (press) state_q <= DELAY;
                    end
                    DELAY: begin
                        if (rcnt_q == RD_LAST) begin
                            pulse_q <= 1'b1;
                            rcnt_q  <= '0;
                            state_q <= REPEAT;
                        end else begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q == RR_LAST) begin
                            pulse_q <= 1'b1;
                            rcnt_q  <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign level = stable_q;
    assign pulse = pulse_q;
endmodule

module btn_conditioner #(
    parameter int unsigned                NUM_BTN         = 5,
    parameter int unsigned                DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [NUM_BTN-1:0]         REPEAT_MASK     = 5'b01100,
    parameter int unsigned                REPEAT_DELAY    = 25_000_000,
    parameter int unsigned                REPEAT_RATE     = 5_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_conditioner_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_MASK[i]),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected strobes go into a scoreboard
// queue; a negedge monitor pops and compares whenever btn_pulse is non-zero.

module tb_btn_conditioner;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    btn_conditioner #(
        .NUM_BTN(5), .DEBOUNCE_CYCLES(DB), .REPEAT_MASK(5'b01100),
        .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [4:0] val; } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int n_tot = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tot++;
        if (act == req) n_pass++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Monitor: missed strobes are flagged once their cycle has passed.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missed_pulse_cycle", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (btn_pulse != 5'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(btn_pulse), 0);
            end else begin
                chk("pulse_cycle", cyc, exp_q[0].cyc);
                chk("pulse_value", int'(btn_pulse), int'(exp_q[0].val));
                void'(exp_q.pop_front());
            end
        end
    end

    int t0;

    initial begin
        #2;
        chk("reset_level", int'(btn_level), 0);
        chk("reset_pulse", int'(btn_pulse), 0);
        step(3);
        rst = 1'b0;
        step(3);

        // 1: clean press on a non-repeating button
        t0 = cyc;
        btn_raw[4] = 1'b1;
        push(t0 + 7, 5'b10000);
        wait_until(t0 + 5);
        chk("t1_level_before", int'(btn_level), 0);
        wait_until(t0 + 6);
        chk("t1_level_rise", int'(btn_level), 5'b10000);
        wait_until(t0 + 20);
        btn_raw[4] = 1'b0;
        wait_until(t0 + 25);
        chk("t1_level_hold", int'(btn_level), 5'b10000);
        wait_until(t0 + 26);
        chk("t1_level_fall", int'(btn_level), 0);
        wait_until(t0 + 35);

        // 2: bounce shorter than the debounce window
        t0 = cyc;
        btn_raw[0] = 1'b1;
        step(3);
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("t2_bounce_level", int'(btn_level), 0);
        end

        // 3: held repeat button, then release
        t0 = cyc;
        btn_raw[2] = 1'b1;
        push(t0 + 7, 5'b00100);
        for (int c = 17; c <= 44; c += 3) push(t0 + c, 5'b00100);
        wait_until(t0 + 40);
        btn_raw[2] = 1'b0;
        wait_until(t0 + 45);
        chk("t3_level_hold", int'(btn_level), 5'b00100);
        wait_until(t0 + 46);
        chk("t3_level_fall", int'(btn_level), 0);
        wait_until(t0 + 65);

        // 4: simultaneous presses on two buttons
        t0 = cyc;
        btn_raw = 5'b11000;
        push(t0 + 7, 5'b11000);
        wait_until(t0 + 6);
        chk("t4_level", int'(btn_level), 5'b11000);
        wait_until(t0 + 10);
        btn_raw = 5'b00000;
        wait_until(t0 + 16);
        chk("t4_level_fall", int'(btn_level), 0);
        wait_until(t0 + 30);

        // 5: reset while held, re-debounced press afterwards
        t0 = cyc;
        btn_raw[2] = 1'b1;
        push(t0 + 7, 5'b00100);
        wait_until(t0 + 15);
        chk("t5_level_pre_rst", int'(btn_level), 5'b00100);
        rst = 1'b1;
        #1;
        chk("t5_async_level", int'(btn_level), 0);
        chk("t5_async_pulse", int'(btn_pulse), 0);
        wait_until(t0 + 17);
        rst = 1'b0;
        push(t0 + 24, 5'b00100);
        wait_until(t0 + 23);
        chk("t5_level_relearn", int'(btn_level), 5'b00100);
        wait_until(t0 + 26);
        btn_raw[2] = 1'b0;
        wait_until(t0 + 32);
        chk("t5_level_fall", int'(btn_level), 0);
        wait_until(t0 + 45);

        // 6: release lands when the repeat counter reaches RATE-1
        t0 = cyc;
        btn_raw[2] = 1'b1;
        push(t0 + 7, 5'b00100);
        push(t0 + 17, 5'b00100);
        push(t0 + 20, 5'b00100);
        push(t0 + 23, 5'b00100);
        push(t0 + 26, 5'b00100);
        wait_until(t0 + 22);
        btn_raw[2] = 1'b0;
        wait_until(t0 + 27);
        chk("t6_level_hold", int'(btn_level), 5'b00100);
        wait_until(t0 + 28);
        chk("t6_level_fall", int'(btn_level), 0);
        wait_until(t0 + 45);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
